// File: rtl/fft_pkg.sv
// Shared FFT definitions: Q-format conversion, log2 helper and the twiddle pair type.
// The conversion is used to fill twiddle ROMs with constant values before the design runs.
package fft_pkg;

   localparam real PI       = 3.14159265358979323846;
   localparam int  TW_MAX_W = 18;

   typedef struct packed {
      logic signed [TW_MAX_W-1:0] re;
      logic signed [TW_MAX_W-1:0] im;
   } twiddle_t;

   function automatic int log2_int(input int n);
      return $clog2(n);
   endfunction

   // Scale by 2^(w-1), round half away from zero, clamp symmetrically to +/-(2^(w-1)-1).
   function automatic int q_round(input real x, input int w);
      real scaled;
      int  r;
      int  max_q;
      scaled = x * real'(1 << (w - 1));
      max_q  = (1 << (w - 1)) - 1;
      if (scaled >= 0.0)
         r = $rtoi($floor(scaled + 0.5));
      else
         r = -$rtoi($floor(-scaled + 0.5));
      if (r > max_q)
         r = max_q;
      else if (r < -max_q)
         r = -max_q;
      return r;
   endfunction

endpackage

// File: rtl/twiddle_qw_table.sv
// Quarter-wave cosine magnitude ROM, C[a] = cos(2*pi*a/N_FFT) for a = 0..N_FFT/4.
// Two registered read ports sharing one advance enable, shaped for block-RAM inference.
module twiddle_qw_table
   import fft_pkg::*;
#(
   parameter int N_FFT = 1024,
   parameter int W     = 16,
   parameter int DEPTH = N_FFT / 4 + 1,
   parameter int AW    = log2_int(N_FFT / 4 + 1),
   parameter int MW    = W - 1
)
(
   input  logic          i_clk,
   input  logic          i_en,
   input  logic [AW-1:0] i_addr_a,
   input  logic [AW-1:0] i_addr_b,
   output logic [MW-1:0] o_data_a,
   output logic [MW-1:0] o_data_b
);

   logic [MW-1:0] rom [DEPTH];

   // Every entry is a constant expression; synthesis folds the table into ROM init data.
   for (genvar a = 0; a < DEPTH; a++) begin : g_fill
      assign rom[a] = MW'(q_round($cos(2.0 * PI * real'(a) / real'(N_FFT)), W));
   end

   // NOTE: memory read registers carry no reset; a reset term would prevent block-RAM mapping,
   // and downstream valid bits already mark these outputs as don't-care after reset.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         o_data_a <= rom[i_addr_a];
         o_data_b <= rom[i_addr_b];
      end
   end

endmodule

// File: rtl/twiddle_rom_qw.sv
// FFT twiddle generator W_N^k from a quarter-wave cosine table, 3-stage valid/ready pipeline.
// Stages: fold index to table addresses, dual table read, apply quadrant and direction signs.
module twiddle_rom_qw
   import fft_pkg::*;
#(
   parameter int N_FFT = 1024,
   parameter int W     = 16
)
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [log2_int(N_FFT)-2:0]    i_k,
   input  logic                          i_inv,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic signed [W-1:0]           o_re,
   output logic signed [W-1:0]           o_im
);

   localparam int KW = log2_int(N_FFT) - 1;
   localparam int AW = log2_int(N_FFT / 4 + 1);
   localparam int MW = W - 1;
   localparam logic [AW-1:0] Q_ADDR = AW'(N_FFT / 4);

   logic          en;
   logic [AW-1:0] k_low;
   logic [AW-1:0] k_comp;

   logic          s1_valid, s1_quad, s1_inv;
   logic [AW-1:0] s1_addr_cos, s1_addr_sin;
   logic          s2_valid, s2_quad, s2_inv;
   logic [MW-1:0] s2_cos_mag, s2_sin_mag;

   logic [W-1:0]        cos_ext, sin_ext;
   logic signed [W-1:0] re_next, im_next;

   // One enable moves the whole pipe; a full pipe with a blocked output freezes every stage.
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

   // Low index bits are k in the first quadrant and m = k - N/4 in the second.
   assign k_low  = AW'(i_k[KW-2:0]);
   assign k_comp = Q_ADDR - k_low;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values and the stages shift together regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         o_valid  <= 1'b0;
         o_re     <= '0;
         o_im     <= '0;
      end else if (en) begin
         s1_valid <= i_valid;
         s2_valid <= s1_valid;
         o_valid  <= s2_valid;
         if (s2_valid) begin
            o_re <= re_next;
            o_im <= im_next;
         end
      end
   end

   // Payload registers are qualified by the valid bits, so they need no reset.
   always_ff @(posedge i_clk) begin
      if (en) begin
         s1_quad     <= i_k[KW-1];
         s1_inv      <= i_inv;
         s1_addr_cos <= i_k[KW-1] ? k_comp : k_low;
         s1_addr_sin <= i_k[KW-1] ? k_low  : k_comp;
         s2_quad     <= s1_quad;
         s2_inv      <= s1_inv;
      end
   end

   twiddle_qw_table #(
      .N_FFT (N_FFT),
      .W     (W)
   ) u_table (
      .i_clk    (i_clk),
      .i_en     (en),
      .i_addr_a (s1_addr_cos),
      .i_addr_b (s1_addr_sin),
      .o_data_a (s2_cos_mag),
      .o_data_b (s2_sin_mag)
   );

   // Magnitudes never exceed 2^(W-1)-1, so negation cannot reach the most negative code,
   // and a zero magnitude negates to plain zero.
   // NOTE: every signal driven in this always_comb gets a value on every path, so no latch.
   always_comb begin
      cos_ext = {1'b0, s2_cos_mag};
      sin_ext = {1'b0, s2_sin_mag};
      re_next = s2_quad ? -cos_ext : cos_ext;
      im_next = s2_inv  ?  sin_ext : -sin_ext;
   end

endmodule

// File: tb/tb_twiddle_rom_qw.sv
// Scoreboard bench for twiddle_rom_qw at N_FFT=1024, W=16: directed vectors, streaming,
// stall hold and mid-flight reset; a monitor pops expected results as outputs are taken.
module tb_twiddle_rom_qw;
   import fft_pkg::*;

   localparam int N_FFT = 1024;
   localparam int W     = 16;
   localparam int KW    = 9;

   logic                i_clk = 1'b0;
   logic                i_rst;
   logic                i_valid;
   logic                o_ready;
   logic [KW-1:0]       i_k;
   logic                i_inv;
   logic                o_valid;
   logic                i_ready;
   logic signed [W-1:0] o_re;
   logic signed [W-1:0] o_im;

   always #5 i_clk = ~i_clk;

   twiddle_rom_qw #(
      .N_FFT (N_FFT),
      .W     (W)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_k     (i_k),
      .i_inv   (i_inv),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_re    (o_re),
      .o_im    (o_im)
   );

   typedef struct {
      int    re;
      int    im;
      int    tol;
      int    cyc;
      bit    chk_lat;
      string name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge i_clk) cyc++;

   task automatic check(input string name, input int act, input int exp, input int tol);
      int diff;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      checks++;
      if (diff > tol) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
      end
   endtask

   function automatic int model_q(input real x);
      real s;
      s = x * 32768.0;
      if (s >= 0.0) return $rtoi($floor(s + 0.5));
      return -$rtoi($floor(-s + 0.5));
   endfunction

   // Monitor: every taken output must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      if (o_valid && i_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got re=%0d im=%0d, expected no output", o_re, o_im);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_re"}, int'(o_re), mon_e.re, mon_e.tol);
            check({mon_e.name, "_im"}, int'(o_im), mon_e.im, mon_e.tol);
            if (mon_e.chk_lat)
               check({mon_e.name, "_latency"}, cyc - mon_e.cyc, 3, 0);
         end
      end
   end

   // Presents one request (called at posedge+1), waits for acceptance, records the expectation.
   task automatic send(input int k, input bit inv, input int ere, input int eim,
                       input int tol, input bit lat, input string name);
      int n;
      n       = 0;
      i_valid = 1'b1;
      i_k     = KW'(k);
      i_inv   = inv;
      @(negedge i_clk);
      while (!o_ready && n < 50) begin
         n++;
         @(negedge i_clk);
      end
      if (!o_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_accept: got no o_ready within 50 cycles, expected acceptance", name);
      end else begin
         sb.push_back('{re: ere, im: eim, tol: tol, cyc: cyc, chk_lat: lat, name: name});
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic send_model(input int k, input bit inv, input bit lat, input string name);
      real ang;
      int  re_e, im_e;
      ang  = 2.0 * PI * real'(k) / real'(N_FFT);
      re_e = model_q($cos(ang));
      im_e = inv ? model_q($sin(ang)) : model_q(-$sin(ang));
      send(k, inv, re_e, im_e, 1, lat, name);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge i_clk);
         n++;
      end
      @(posedge i_clk);
      #1;
      check({name, "_drained"}, sb.size(), 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   int hold_re, hold_im;

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_k     = '0;
      i_inv   = 1'b0;
      i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_o_valid", int'(o_valid), 0, 0);
      check("reset_o_re", int'(o_re), 0, 0);
      check("reset_o_im", int'(o_im), 0, 0);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      check("ready_after_reset", int'(o_ready), 1, 0);

      // Hand-computed vectors, including the +/-1.0 and zero-magnitude corners.
      send(0,   1'b0,  32767,      0, 0, 1'b1, "k0_fwd");
      send(0,   1'b1,  32767,      0, 0, 1'b1, "k0_inv");
      send(256, 1'b0,      0, -32767, 0, 1'b1, "k256_fwd");
      send(256, 1'b1,      0,  32767, 0, 1'b1, "k256_inv");
      send(128, 1'b0,  23170, -23170, 0, 1'b1, "k128_fwd");
      send(128, 1'b1,  23170,  23170, 0, 1'b1, "k128_inv");
      send(511, 1'b0, -32767,   -201, 0, 1'b1, "k511_fwd");
      send(511, 1'b1, -32767,    201, 0, 1'b1, "k511_inv");
      send(384, 1'b0, -23170, -23170, 0, 1'b1, "k384_fwd");
      send(1,   1'b0,  32767,   -201, 0, 1'b1, "k1_fwd");
      drain("directed");

      // Full sweep with alternating direction, one request per cycle.
      for (int k = 0; k < N_FFT / 2; k++)
         send_model(k, k[0], 1'b1, "sweep");
      drain("sweep");

      // Fill the pipe against a blocked output, hold, then release.
      i_ready = 1'b0;
      send_model(64,  1'b0, 1'b0, "stall_a");
      send_model(300, 1'b1, 1'b0, "stall_b");
      send_model(450, 1'b0, 1'b0, "stall_c");
      hold_re = int'(o_re);
      hold_im = int'(o_im);
      check("stall_full_valid", int'(o_valid), 1, 0);
      check("stall_first_re", hold_re, model_q($cos(2.0 * PI * 64.0 / 1024.0)), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("stall_o_ready", int'(o_ready), 0, 0);
         check("stall_o_valid", int'(o_valid), 1, 0);
         check("stall_hold_re", int'(o_re), hold_re, 0);
         check("stall_hold_im", int'(o_im), hold_im, 0);
      end
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      drain("stall");

      // Reset with two samples in flight: they must vanish without output.
      send_model(128, 1'b0, 1'b0, "flushed_a");
      send_model(64,  1'b1, 1'b0, "flushed_b");
      i_rst = 1'b1;
      #1;
      check("midreset_o_valid", int'(o_valid), 0, 0);
      check("midreset_o_re", int'(o_re), 0, 0);
      check("midreset_o_im", int'(o_im), 0, 0);
      sb.delete();
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         check("post_reset_no_stale", int'(o_valid), 0, 0);
      end
      @(posedge i_clk);
      #1;
      check("post_reset_ready", int'(o_ready), 1, 0);
      send(0,   1'b1, 32767,      0, 0, 1'b1, "post_reset_k0");
      send(256, 1'b0,     0, -32767, 0, 1'b1, "post_reset_k256");
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
